// File: rtl/mem_loader.sv
// mem_loader: host-side writer for the instruction and data memories.
// A framed byte stream (CMD, ADDR, COUNT, COUNT x {HI, LO}) is accepted
// over a valid/ready handshake. Each word goes out through a shared write
// port as a single-cycle im_we/dm_we pulse. The core stays held
// (core_run=0) until a RUN command arrives.
// Optional feature: define LOADER_CHECKSUM_EN to expect a trailing XOR
// checksum byte per frame (covers ADDR, COUNT and all data bytes).
module mem_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter logic [7:0]  CMD_IM  = 8'hA1,
  parameter logic [7:0]  CMD_DM  = 8'hA2,
  parameter logic [7:0]  CMD_RUN = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic              dm_we,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              core_run,
  output logic              busy,
  output logic              err
);

  // Frame parser states. CSUM exists only when the checksum is built in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    COUNT   = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    WRITE   = 3'd5,
    CSUM    = 3'd6
`else
    WRITE   = 3'd5
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                target_dm_q, target_dm_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  // Words left in the frame; needs 9 bits because COUNT=0 means 256.
  logic [8:0]          remaining_q, remaining_d;
  logic                core_run_q, core_run_d;
  logic                err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                accept;
  logic                last_word;

  // Handshake: the loader only refuses bytes during the WRITE cycle and reset.
  always_comb begin
    in_ready  = rst_n && (state_q != WRITE);
    accept    = in_valid && in_ready;
    last_word = (remaining_q == 9'd1);
  end

  // Next-state and datapath updates for the frame parser.
  always_comb begin
    state_d     = state_q;
    target_dm_d = target_dm_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    remaining_d = remaining_q;
    core_run_d  = core_run_q;
    err_d       = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((in_data == CMD_IM) || (in_data == CMD_DM)) begin
            target_dm_d = (in_data == CMD_DM);
            core_run_d  = 1'b0;
            state_d     = ADDR;
`ifdef LOADER_CHECKSUM_EN
            csum_d      = 8'h00;
`endif
          end else if (in_data == CMD_RUN) begin
            core_run_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ADDR: begin
        if (accept) begin
          w_addr_d = in_data[ADDR_W-1:0];
          state_d  = COUNT;
`ifdef LOADER_CHECKSUM_EN
          csum_d   = csum_q ^ in_data;
`endif
        end
      end

      COUNT: begin
        if (accept) begin
          remaining_d = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          state_d     = DATA_HI;
`ifdef LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ in_data;
`endif
        end
      end

      DATA_HI: begin
        if (accept) begin
          w_data_d[DATA_W-1 -: 8] = in_data;
          state_d                 = DATA_LO;
`ifdef LOADER_CHECKSUM_EN
          csum_d                  = csum_q ^ in_data;
`endif
        end
      end

      DATA_LO: begin
        if (accept) begin
          w_data_d[7:0] = in_data;
          state_d       = WRITE;
`ifdef LOADER_CHECKSUM_EN
          csum_d        = csum_q ^ in_data;
`endif
        end
      end

      WRITE: begin
        remaining_d = remaining_q - 9'd1;
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = IDLE;
`endif
        end else begin
          w_addr_d = w_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_d  = DATA_HI;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          if (in_data != csum_q) begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      target_dm_q <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      remaining_q <= '0;
      core_run_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      target_dm_q <= target_dm_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      remaining_q <= remaining_d;
      core_run_q  <= core_run_d;
      err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Output decode: write strobes only in WRITE, steered by the latched target.
  always_comb begin
    im_we    = rst_n && (state_q == WRITE) && !target_dm_q;
    dm_we    = rst_n && (state_q == WRITE) &&  target_dm_q;
    w_addr   = w_addr_q;
    w_data   = w_data_q;
    core_run = core_run_q;
    busy     = (state_q != IDLE);
    err      = err_q;
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed stimulus for mem_loader with hand-computed
// expected values, checked by immediate assertions at each step.
module tb_mem_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic        dm_we;
  logic [7:0]  w_addr;
  logic [15:0] w_data;
  logic        core_run;
  logic        busy;
  logic        err;

  int nVectors     = 0;
  int nMiscompares = 0;

  mem_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .im_we    (im_we),
    .dm_we    (dm_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .core_run (core_run),
    .busy     (busy),
    .err      (err)
  );

  // 100 MHz-style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    assert (observed === expected)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one byte from a negedge, wait (bounded) for ready, and return at
  // the negedge right after the transferring posedge.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles;
    in_data    = b;
    in_valid   = 1'b1;
    waitCycles = 0;
    while (!in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Same as applyStimulus but with one idle (in_valid=0) cycle first.
  task automatic applyGapped(input logic [7:0] b);
    in_valid = 1'b0;
    @(negedge clk);
    applyStimulus(b);
  endtask

  // Trailing checksum byte, only present in the checksum build.
  task automatic applyCsum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(b);
`else
    in_data = b;
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_im_we",    {31'd0, im_we},    32'd0);
    checkOutput("rst_dm_we",    {31'd0, dm_we},    32'd0);
    checkOutput("rst_busy",     {31'd0, busy},     32'd0);
    checkOutput("rst_core_run", {31'd0, core_run}, 32'd0);
    checkOutput("rst_err",      {31'd0, err},      32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_w_addr",   {24'd0, w_addr},   32'd0);
    checkOutput("rst_w_data",   {16'd0, w_data},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Scenario 1: A1 10 02 12 34 56 78, then A5
    $display("[TB] scenario 1: instruction load of two words");
    applyStimulus(8'hA1);
    checkOutput("s1_busy_after_cmd", {31'd0, busy},     32'd1);
    checkOutput("s1_core_run_held",  {31'd0, core_run}, 32'd0);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    checkOutput("s1_no_we_before_lo", {31'd0, im_we}, 32'd0);
    applyStimulus(8'h34);
    checkOutput("s1_w0_im_we",    {31'd0, im_we},    32'd1);
    checkOutput("s1_w0_dm_we",    {31'd0, dm_we},    32'd0);
    checkOutput("s1_w0_addr",     {24'd0, w_addr},   32'h10);
    checkOutput("s1_w0_data",     {16'd0, w_data},   32'h1234);
    checkOutput("s1_w0_in_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(8'h56);
    applyStimulus(8'h78);
    checkOutput("s1_w1_im_we", {31'd0, im_we},  32'd1);
    checkOutput("s1_w1_dm_we", {31'd0, dm_we},  32'd0);
    checkOutput("s1_w1_addr",  {24'd0, w_addr}, 32'h11);
    checkOutput("s1_w1_data",  {16'd0, w_data}, 32'h5678);
    applyCsum(8'h1A);
    @(negedge clk);
    checkOutput("s1_idle_busy",    {31'd0, busy},     32'd0);
    checkOutput("s1_idle_im_we",   {31'd0, im_we},    32'd0);
    checkOutput("s1_hold_addr",    {24'd0, w_addr},   32'h11);
    checkOutput("s1_hold_data",    {16'd0, w_data},   32'h5678);
    checkOutput("s1_core_run_pre", {31'd0, core_run}, 32'd0);
    applyStimulus(8'hA5);
    checkOutput("s1_core_run", {31'd0, core_run}, 32'd1);
    checkOutput("s1_run_busy", {31'd0, busy},     32'd0);

    // Scenario 2: A2 FF 02 AA BB CC DD with address wrap
    $display("[TB] scenario 2: data load with address wrap");
    applyStimulus(8'hA2);
    checkOutput("s2_core_run_cleared", {31'd0, core_run}, 32'd0);
    applyStimulus(8'hFF);
    applyStimulus(8'h02);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    checkOutput("s2_w0_dm_we", {31'd0, dm_we},  32'd1);
    checkOutput("s2_w0_im_we", {31'd0, im_we},  32'd0);
    checkOutput("s2_w0_addr",  {24'd0, w_addr}, 32'hFF);
    checkOutput("s2_w0_data",  {16'd0, w_data}, 32'hAABB);
    applyStimulus(8'hCC);
    applyStimulus(8'hDD);
    checkOutput("s2_w1_dm_we", {31'd0, dm_we},  32'd1);
    checkOutput("s2_w1_addr",  {24'd0, w_addr}, 32'h00);
    checkOutput("s2_w1_data",  {16'd0, w_data}, 32'hCCDD);
    checkOutput("s2_err",      {31'd0, err},    32'd0);
    applyCsum(8'hFD);
    @(negedge clk);
    checkOutput("s2_idle_busy", {31'd0, busy}, 32'd0);

    // Scenario 3: scenario 1 frame with in_valid toggled every other cycle
    $display("[TB] scenario 3: stalled byte stream");
    applyGapped(8'hA1);
    applyGapped(8'h10);
    applyGapped(8'h02);
    applyGapped(8'h12);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("s3_stall_no_we", {31'd0, im_we}, 32'd0);
    checkOutput("s3_stall_busy",  {31'd0, busy},  32'd1);
    applyStimulus(8'h34);
    checkOutput("s3_w0_im_we",    {31'd0, im_we},    32'd1);
    checkOutput("s3_w0_addr",     {24'd0, w_addr},   32'h10);
    checkOutput("s3_w0_data",     {16'd0, w_data},   32'h1234);
    checkOutput("s3_w0_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("s3_after_w0_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("s3_after_w0_im_we",    {31'd0, im_we},    32'd0);
    applyGapped(8'h56);
    applyGapped(8'h78);
    checkOutput("s3_w1_im_we",    {31'd0, im_we},    32'd1);
    checkOutput("s3_w1_dm_we",    {31'd0, dm_we},    32'd0);
    checkOutput("s3_w1_addr",     {24'd0, w_addr},   32'h11);
    checkOutput("s3_w1_data",     {16'd0, w_data},   32'h5678);
    checkOutput("s3_w1_in_ready", {31'd0, in_ready}, 32'd0);
    applyCsum(8'h1A);
    @(negedge clk);

    // Scenario 4: reset mid-frame, then an illegal command byte
    $display("[TB] scenario 4: reset mid-frame and bad command");
    applyStimulus(8'hA1);
    applyStimulus(8'h05);
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("s4_rst_im_we",  {31'd0, im_we},  32'd0);
    checkOutput("s4_rst_busy",   {31'd0, busy},   32'd0);
    checkOutput("s4_rst_w_addr", {24'd0, w_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("s4_post_busy", {31'd0, busy}, 32'd0);
    applyStimulus(8'h33);
    checkOutput("s4_err",       {31'd0, err},   32'd1);
    checkOutput("s4_idle_busy", {31'd0, busy},  32'd0);
    checkOutput("s4_no_we",     {31'd0, im_we}, 32'd0);

    // Scenario 5: core_run falls on a load command and stays low
    $display("[TB] scenario 5: core_run cleared by a load");
    applyStimulus(8'hA5);
    checkOutput("s5_core_run_set", {31'd0, core_run}, 32'd1);
    applyStimulus(8'hA1);
    checkOutput("s5_core_run_fall", {31'd0, core_run}, 32'd0);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    checkOutput("s5_im_we",          {31'd0, im_we},    32'd1);
    checkOutput("s5_addr",           {24'd0, w_addr},   32'h00);
    checkOutput("s5_data",           {16'd0, w_data},   32'h0001);
    checkOutput("s5_core_run_write", {31'd0, core_run}, 32'd0);
    applyCsum(8'h00);
    @(negedge clk);
    checkOutput("s5_core_run_after", {31'd0, core_run}, 32'd0);
    checkOutput("s5_busy_after",     {31'd0, busy},     32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Scenario 6: checksum good, then checksum bad
    $display("[TB] scenario 6: frame checksum");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'hA2);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    checkOutput("s6a_dm_we", {31'd0, dm_we},  32'd1);
    checkOutput("s6a_addr",  {24'd0, w_addr}, 32'h00);
    checkOutput("s6a_data",  {16'd0, w_data}, 32'h1234);
    applyStimulus(8'h27);
    checkOutput("s6a_err",  {31'd0, err},  32'd0);
    checkOutput("s6a_busy", {31'd0, busy}, 32'd0);
    applyStimulus(8'hA2);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    checkOutput("s6b_dm_we", {31'd0, dm_we},  32'd1);
    checkOutput("s6b_addr",  {24'd0, w_addr}, 32'h00);
    checkOutput("s6b_data",  {16'd0, w_data}, 32'h1234);
    applyStimulus(8'h00);
    checkOutput("s6b_err",  {31'd0, err},  32'd1);
    checkOutput("s6b_busy", {31'd0, busy}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
